// File: rtl/corescore_pkg.sv
// Shared stream constants, grant-width helper and arbiter state encoding.
package corescore_pkg;

    localparam int STREAM_DW = 8;

    function automatic int grant_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_e;

endpackage

// File: rtl/stream_packet_arbiter_if.sv
// Bundle of the N source streams, the merged emitter stream and arbiter status.
interface stream_packet_arbiter_if #(
    parameter int NUM_SOURCES = 4,
    parameter int CNT_W       = 16
);
    import corescore_pkg::*;

    localparam int GRANT_W = grant_width(NUM_SOURCES);

    logic [STREAM_DW*NUM_SOURCES-1:0] i_tdata;
    logic [NUM_SOURCES-1:0]           i_tlast;
    logic [NUM_SOURCES-1:0]           i_tvalid;
    logic [NUM_SOURCES-1:0]           o_tready;
    logic [STREAM_DW-1:0]             o_tdata;
    logic                             o_tlast;
    logic                             o_tvalid;
    logic                             i_tready;
    logic [GRANT_W-1:0]               o_grant;
    logic                             o_busy;
    logic [CNT_W-1:0]                 o_pkt_count;

    modport slave (
        input  i_tdata, i_tlast, i_tvalid, i_tready,
        output o_tready, o_tdata, o_tlast, o_tvalid, o_grant, o_busy, o_pkt_count
    );

    modport master (
        output i_tdata, i_tlast, i_tvalid, i_tready,
        input  o_tready, o_tdata, o_tlast, o_tvalid, o_grant, o_busy, o_pkt_count
    );

endinterface

// File: rtl/stream_rr_pick.sv
// Round-robin picker: first set req at or after ptr, wrapping; purely combinational,
// zero latency, no backpressure.
module stream_rr_pick
    import corescore_pkg::*;
#(
    parameter int NUM_SOURCES = 4,
    parameter int GRANT_W     = grant_width(NUM_SOURCES)
) (
    input  logic [NUM_SOURCES-1:0] req,
    input  logic [GRANT_W-1:0]     ptr,
    output logic                   any,
    output logic [GRANT_W-1:0]     idx
);

    localparam logic [GRANT_W:0] N_X = (GRANT_W + 1)'(NUM_SOURCES);

    logic [NUM_SOURCES-1:0] rot;
    logic [GRANT_W-1:0]     off;
    logic [GRANT_W:0]       sum;

    always_comb begin
        // Rotate so bit 0 is the source at ptr, then take the lowest set bit.
        rot = NUM_SOURCES'({req, req} >> ptr);
        any = 1'b0;
        off = '0;
        for (int i = NUM_SOURCES - 1; i >= 0; i--) begin
            if (rot[i]) begin
                any = 1'b1;
                off = GRANT_W'(i);
            end
        end
        sum = {1'b0, ptr} + {1'b0, off};
        if (sum >= N_X) begin
            sum = sum - N_X;
        end
        idx = sum[GRANT_W-1:0];
    end

endmodule

// File: rtl/stream_packet_arbiter.sv
// Packet-atomic round-robin merge of N byte streams onto one registered stream.
// Latency: 1-cycle arbitration bubble + 1 register stage; per-source tready follows the output slot.
module stream_packet_arbiter
    import corescore_pkg::*;
#(
    parameter int NUM_SOURCES = 4,
    parameter int CNT_W       = 16
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    stream_packet_arbiter_if.slave bus
);

    localparam int                 GRANT_W  = grant_width(NUM_SOURCES);
    localparam logic [GRANT_W-1:0] LAST_SRC = GRANT_W'(NUM_SOURCES - 1);

    arb_state_e             state_q, state_d;
    logic [GRANT_W-1:0]     grant_q, grant_d;
    logic [GRANT_W-1:0]     ptr_q, ptr_d;
    logic [STREAM_DW-1:0]   tdata_q, tdata_d;
    logic                   tlast_q, tlast_d;
    logic                   tvalid_q, tvalid_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;

    logic                   pick_any;
    logic [GRANT_W-1:0]     pick_idx;
    logic [NUM_SOURCES-1:0] grant_oh;
    logic [NUM_SOURCES-1:0] tready;
    logic [STREAM_DW-1:0]   sel_data;
    logic                   sel_last;
    logic                   locked;
    logic                   ld;
    logic                   accept;

    stream_rr_pick #(
        .NUM_SOURCES(NUM_SOURCES),
        .GRANT_W    (GRANT_W)
    ) u_pick (
        .req(bus.i_tvalid),
        .ptr(ptr_q),
        .any(pick_any),
        .idx(pick_idx)
    );

    always_comb begin
        grant_oh = NUM_SOURCES'(1) << grant_q;
        sel_data = '0;
        for (int k = 0; k < NUM_SOURCES; k++) begin
            if (grant_oh[k]) begin
                sel_data = sel_data | bus.i_tdata[k*STREAM_DW +: STREAM_DW];
            end
        end
        sel_last = |(bus.i_tlast & grant_oh);

        locked = (state_q == ST_LOCKED);
        ld     = !tvalid_q || bus.i_tready;
        tready = (locked && ld && !i_rst) ? grant_oh : '0;
        accept = |(bus.i_tvalid & tready);

        state_d  = state_q;
        grant_d  = grant_q;
        ptr_d    = ptr_q;
        tdata_d  = tdata_q;
        tlast_d  = tlast_q;
        tvalid_d = tvalid_q;
        cnt_d    = cnt_q;

        if (accept) begin
            tdata_d  = sel_data;
            tlast_d  = sel_last;
            tvalid_d = 1'b1;
        end else if (bus.i_tready) begin
            tvalid_d = 1'b0;
        end

        if (tvalid_q && bus.i_tready && tlast_q) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        unique case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    grant_d = pick_idx;
                    state_d = ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                // Lock is released only by the granted source's tlast beat.
                if (accept && sel_last) begin
                    state_d = ST_IDLE;
                    ptr_d   = (grant_q == LAST_SRC) ? '0 : grant_q + GRANT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= ST_IDLE;
            grant_q  <= '0;
            ptr_q    <= '0;
            tdata_q  <= '0;
            tlast_q  <= 1'b0;
            tvalid_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            ptr_q    <= ptr_d;
            tdata_q  <= tdata_d;
            tlast_q  <= tlast_d;
            tvalid_q <= tvalid_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.o_tready    = tready;
    assign bus.o_tdata     = tdata_q;
    assign bus.o_tlast     = tlast_q;
    assign bus.o_tvalid    = tvalid_q;
    assign bus.o_grant     = grant_q;
    assign bus.o_busy      = locked;
    assign bus.o_pkt_count = cnt_q;

endmodule
